// File: rtl/path_replayer.sv
// Replays a move stream through a 16x16 maze and reports a pass/fail verdict.
// Latency: 3 cycles per move (accept, memory read, evaluate); verdict registered.
// Backpressure: move_ready is high only while waiting for a move; no skid storage.
module path_replayer #(
    parameter logic [3:0] START_X = 4'd0,
    parameter logic [3:0] START_Y = 4'd0,
    parameter logic [3:0] GOAL_X  = 4'd15,
    parameter logic [3:0] GOAL_Y  = 4'd15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       move_valid,
    input  logic [1:0] move,
    input  logic       move_last,
    output logic       move_ready,
    output logic       mem_rd,
    output logic [3:0] mem_x,
    output logic [3:0] mem_y,
    input  logic       mem_data,
    output logic [3:0] pos_x,
    output logic [3:0] pos_y,
    output logic [7:0] step_count,
    output logic       busy,
    output logic       pass,
    output logic       fail,
    output logic [1:0] err_code
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCEPT = 3'd1,
        READ   = 3'd2,
        EVAL   = 3'd3,
        PASS   = 3'd4,
        FAIL   = 3'd5
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_OOB  = 2'b01;
    localparam logic [1:0] ERR_WALL = 2'b10;
    localparam logic [1:0] ERR_GOAL = 2'b11;

    state_t     state;
    logic       last_q;
    logic [4:0] next_x;
    logic [4:0] next_y;
    logic       out_of_bounds;

    // Candidate position in 5-bit arithmetic so that wrap past 0 or 15 shows up in bit 4.
    always_comb begin
        next_x = {1'b0, pos_x};
        next_y = {1'b0, pos_y};
        case (move)
            2'b00:   next_y = {1'b0, pos_y} - 5'd1;
            2'b01:   next_x = {1'b0, pos_x} + 5'd1;
            2'b10:   next_x = {1'b0, pos_x} - 5'd1;
            default: next_y = {1'b0, pos_y} + 5'd1;
        endcase
        out_of_bounds = next_x[4] | next_y[4];
    end

    // Session FSM; mem_x/mem_y double as the captured candidate between READ and EVAL.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            pos_x      <= START_X;
            pos_y      <= START_Y;
            step_count <= 8'd0;
            move_ready <= 1'b0;
            mem_rd     <= 1'b0;
            mem_x      <= 4'd0;
            mem_y      <= 4'd0;
            busy       <= 1'b0;
            pass       <= 1'b0;
            fail       <= 1'b0;
            err_code   <= ERR_NONE;
            last_q     <= 1'b0;
        end else begin
            case (state)
                IDLE, PASS, FAIL: begin
                    if (start) begin
                        state      <= ACCEPT;
                        pos_x      <= START_X;
                        pos_y      <= START_Y;
                        step_count <= 8'd0;
                        pass       <= 1'b0;
                        fail       <= 1'b0;
                        err_code   <= ERR_NONE;
                        busy       <= 1'b1;
                        move_ready <= 1'b1;
                    end
                end
                ACCEPT: begin
                    if (move_valid) begin
                        move_ready <= 1'b0;
                        if (out_of_bounds) begin
                            state    <= FAIL;
                            fail     <= 1'b1;
                            busy     <= 1'b0;
                            err_code <= ERR_OOB;
                        end else begin
                            state  <= READ;
                            mem_rd <= 1'b1;
                            mem_x  <= next_x[3:0];
                            mem_y  <= next_y[3:0];
                            last_q <= move_last;
                        end
                    end
                end
                READ: begin
                    mem_rd <= 1'b0;
                    state  <= EVAL;
                end
                EVAL: begin
                    if (mem_data) begin
                        state    <= FAIL;
                        fail     <= 1'b1;
                        busy     <= 1'b0;
                        err_code <= ERR_WALL;
                    end else begin
                        pos_x <= mem_x;
                        pos_y <= mem_y;
                        if (step_count != 8'hFF) begin
                            step_count <= step_count + 8'd1;
                        end
                        if (!last_q) begin
                            state      <= ACCEPT;
                            move_ready <= 1'b1;
                        end else if (mem_x == GOAL_X && mem_y == GOAL_Y) begin
                            state <= PASS;
                            pass  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state    <= FAIL;
                            fail     <= 1'b1;
                            busy     <= 1'b0;
                            err_code <= ERR_GOAL;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    move_ready <= 1'b0;
                    mem_rd     <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_path_replayer.sv
// Directed bench for path_replayer with a registered maze memory model.
// Inputs change and outputs are sampled on the falling clock edge.
// Every wait on the design is bounded by a cycle budget.
module tb_path_replayer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       move_valid;
    logic [1:0] move;
    logic       move_last;
    logic       move_ready;
    logic       mem_rd;
    logic [3:0] mem_x;
    logic [3:0] mem_y;
    logic       mem_data;
    logic [3:0] pos_x;
    logic [3:0] pos_y;
    logic [7:0] step_count;
    logic       busy;
    logic       pass;
    logic       fail;
    logic [1:0] err_code;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rd_cnt   = 0;
    logic [3:0] rd_x = 4'd0;
    logic [3:0] rd_y = 4'd0;
    bit wall [16][16];

    path_replayer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .move_valid (move_valid),
        .move       (move),
        .move_last  (move_last),
        .move_ready (move_ready),
        .mem_rd     (mem_rd),
        .mem_x      (mem_x),
        .mem_y      (mem_y),
        .mem_data   (mem_data),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .step_count (step_count),
        .busy       (busy),
        .pass       (pass),
        .fail       (fail),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Maze memory: data is valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (mem_rd) mem_data <= wall[mem_y][mem_x];
    end

    // Read monitor.
    always @(negedge clk) begin
        if (mem_rd) begin
            rd_cnt <= rd_cnt + 1;
            rd_x   <= mem_x;
            rd_y   <= mem_y;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present one move and hold it until it transfers; returns on the next falling edge.
    task automatic send_move(input logic [1:0] d, input logic l);
        move_valid = 1'b1;
        move       = d;
        move_last  = l;
        for (int n = 0; n < 20; n++) begin
            if (move_ready) begin
                @(negedge clk);
                move_valid = 1'b0;
                move_last  = 1'b0;
                return;
            end
            @(negedge clk);
        end
        move_valid = 1'b0;
        move_last  = 1'b0;
        check("ready_timeout", move_ready, 1);
    endtask

    task automatic wait_done();
        for (int n = 0; n < 20; n++) begin
            if (!busy) return;
            @(negedge clk);
        end
        check("busy_timeout", busy, 0);
    endtask

    task automatic clear_maze();
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++)
                wall[y][x] = 1'b0;
    endtask

    initial begin
        int rd0;
        int xfer [$];
        int rds  [$];
        int ready_seen;

        rst        = 1'b0;
        start      = 1'b0;
        move_valid = 1'b0;
        move       = 2'b00;
        move_last  = 1'b0;
        mem_data   = 1'b0;
        clear_maze();

        // Reset values.
        repeat (2) @(negedge clk);
        check("rst_pos", {pos_x, pos_y}, 8'h00);
        check("rst_step", step_count, 0);
        check("rst_flags", {move_ready, mem_rd, busy, pass, fail}, 5'b0);
        check("rst_err", err_code, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_after_rst", {busy, move_ready}, 2'b00);

        // Full legal path to the goal.
        rd0 = rd_cnt;
        do_start();
        check("start_busy", busy, 1);
        for (int i = 0; i < 15; i++) send_move(2'b01, 1'b0);
        for (int i = 0; i < 15; i++) send_move(2'b11, i == 14);
        wait_done();
        check("goal_pass_fail", {pass, fail}, 2'b10);
        check("goal_pos", {pos_x, pos_y}, 8'hFF);
        check("goal_step", step_count, 30);
        check("goal_err", err_code, 0);
        check("goal_reads", rd_cnt - rd0, 30);

        // Moves offered after the verdict are refused and change nothing.
        ready_seen = 0;
        move_valid = 1'b1;
        move       = 2'b10;
        for (int i = 0; i < 4; i++) begin
            if (move_ready) ready_seen++;
            @(negedge clk);
        end
        move_valid = 1'b0;
        check("post_pass_ready", ready_seen, 0);
        check("post_pass_pos", {pos_x, pos_y}, 8'hFF);

        // Wall directly to the right of the start cell.
        wall[0][1] = 1'b1;
        rd0 = rd_cnt;
        do_start();
        check("restart_clears", {pass, fail, err_code}, 4'b0);
        send_move(2'b01, 1'b0);
        wait_done();
        check("wall_fail", {pass, fail}, 2'b01);
        check("wall_err", err_code, 2);
        check("wall_pos", {pos_x, pos_y}, 8'h00);
        check("wall_step", step_count, 0);
        check("wall_reads", rd_cnt - rd0, 1);
        check("wall_addr", {rd_x, rd_y}, 8'h10);
        clear_maze();

        // First move off the top edge.
        rd0 = rd_cnt;
        do_start();
        send_move(2'b00, 1'b0);
        wait_done();
        check("oob_fail", {pass, fail}, 2'b01);
        check("oob_err", err_code, 1);
        check("oob_reads", rd_cnt - rd0, 0);

        // Stream ends away from the goal.
        do_start();
        send_move(2'b01, 1'b0);
        send_move(2'b11, 1'b1);
        wait_done();
        check("offgoal_fail", {pass, fail}, 2'b01);
        check("offgoal_err", err_code, 3);
        check("offgoal_pos", {pos_x, pos_y}, 8'h11);
        check("offgoal_step", step_count, 2);

        // Continuous valid: one transfer every 3 cycles, read one cycle later.
        do_start();
        move_valid = 1'b1;
        move       = 2'b01;
        move_last  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (move_ready) xfer.push_back(cyc);
            if (mem_rd) rds.push_back(cyc);
            @(negedge clk);
        end
        move_valid = 1'b0;
        check("tput_xfers", xfer.size(), 4);
        check("tput_reads", rds.size(), 4);
        if (xfer.size() >= 3 && rds.size() >= 2) begin
            check("tput_gap0", xfer[1] - xfer[0], 3);
            check("tput_gap1", xfer[2] - xfer[1], 3);
            check("tput_rd0", rds[0] - xfer[0], 1);
            check("tput_rd1", rds[1] - xfer[1], 1);
        end
        check("tput_pos", {pos_x, pos_y}, 8'h40);
        check("tput_step", step_count, 4);
        send_move(2'b00, 1'b1);
        wait_done();
        check("tput_end_err", err_code, 1);

        // Step counter saturates at 255 without an error.
        do_start();
        for (int i = 0; i < 128; i++) begin
            send_move(2'b01, 1'b0);
            send_move(2'b10, 1'b0);
        end
        check("sat_step", step_count, 255);
        check("sat_busy", {busy, fail}, 2'b10);
        send_move(2'b10, 1'b1);
        wait_done();
        check("sat_end_err", err_code, 1);
        check("sat_end_step", step_count, 255);

        // Reset in the READ cycle of the third move.
        do_start();
        send_move(2'b01, 1'b0);
        send_move(2'b01, 1'b0);
        send_move(2'b01, 1'b0);
        check("pre_rst_read", mem_rd, 1);
        rst = 1'b0;
        #1;
        check("mid_rst_pos", {pos_x, pos_y}, 8'h00);
        check("mid_rst_step", step_count, 0);
        check("mid_rst_flags", {move_ready, mem_rd, busy, pass, fail}, 5'b0);
        check("mid_rst_mem", {mem_x, mem_y, err_code}, 10'b0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_idle", {busy, pass, fail, move_ready}, 4'b0);
        do_start();
        send_move(2'b11, 1'b1);
        wait_done();
        check("replay_pos", {pos_x, pos_y}, 8'h01);
        check("replay_step", step_count, 1);
        check("replay_err", err_code, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
